dm_store_buffer: RTL and testbench

Store buffer between the CPU memory stage and the data memory `DM`. It accepts word, halfword and byte stores from the pipeline, queues them in a small FIFO, and drains them in order into the DM write port whenever the DM is ready. It also checks pipeline loads against pending stores: it either forwards the data or stalls the load, so loads never read stale memory.

---
 rtl/dm_store_buffer_pkg.sv | 34 +++
 rtl/dm_store_buffer_match.sv | 72 +++++++
 rtl/dm_store_buffer.sv | 102 ++++++++++
 tb/tb_dm_store_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_store_buffer_pkg.sv
// rtl/dm_store_buffer_pkg.sv - store buffer op codes, entry field widths, default depth and load data extraction
package dm_store_buffer_pkg;

    localparam logic [1:0] LS_w = 2'b00;
    localparam logic [1:0] LS_h = 2'b01;
    localparam logic [1:0] LS_b = 2'b10;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_OP_W   = 2;
    localparam int SB_PC_W   = 32;

    // Same right-aligned, zero-extended extraction the DM read path applies
    function automatic logic [SB_DATA_W-1:0] ld_extract(
        input logic [SB_DATA_W-1:0] word,
        input logic [SB_OP_W-1:0]   op,
        input logic [1:0]           off
    );
        logic [SB_DATA_W-1:0] sh;
        case (op)
            LS_h: begin
                sh = word >> {off[1], 4'b0000};
                ld_extract = {16'h0000, sh[15:0]};
            end
            LS_b: begin
                sh = word >> {off, 3'b000};
                ld_extract = {24'h000000, sh[7:0]};
            end
            default: ld_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_buffer_match.sv
// rtl/dm_store_buffer_match.sv - youngest pending-store match and load forwarding/stall decision (SB_FWD_EN)
module sb_match
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic [SB_ADDR_W-1:0] addr_q [DEPTH],
    input  logic [SB_DATA_W-1:0] data_q [DEPTH],
    input  logic [SB_OP_W-1:0]   op_q   [DEPTH],
    input  logic [PTR_W-1:0]     head,
    input  logic [PTR_W:0]       count,
    input  logic                 ld_valid,
    input  logic [SB_ADDR_W-1:0] ld_addr,
    input  logic [SB_OP_W-1:0]   ld_op,
    output logic                 ld_hit,
    output logic [SB_DATA_W-1:0] ld_data,
    output logic                 ld_stall
);

    logic             found;
    logic [PTR_W-1:0] yidx;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last word-address match wins
    always_comb begin
        found = 1'b0;
        yidx  = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
                found = 1'b1;
                yidx  = idx;
            end
        end
    end

`ifdef SB_FWD_EN
    // Forward from a full word or an exactly matching sub-word store, otherwise stall
    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        if (ld_valid && found) begin
            if (op_q[yidx] == LS_w) begin
                ld_hit  = 1'b1;
                ld_data = ld_extract(data_q[yidx], ld_op, ld_addr[1:0]);
            end else if ((op_q[yidx] == ld_op) && (addr_q[yidx][1:0] == ld_addr[1:0])) begin
                ld_hit  = 1'b1;
                ld_data = ld_extract(data_q[yidx], op_q[yidx], 2'b00);
            end else begin
                ld_stall = 1'b1;
            end
        end
    end
`else
    logic unused_fields;

    // Without forwarding any pending match holds the load until the store drains
    always_comb begin
        ld_hit        = 1'b0;
        ld_data       = '0;
        ld_stall      = ld_valid && found;
        unused_fields = ^{ld_op, ld_addr[1:0]};
        for (int k = 0; k < DEPTH; k++) begin
            unused_fields = unused_fields ^ (^{data_q[k], op_q[k], addr_q[k][1:0]});
        end
    end
`endif

endmodule

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - in-order store FIFO draining into the DM write port with load hazard check (SB_FWD_EN)
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [SB_ADDR_W-1:0] st_addr,
    input  logic [SB_DATA_W-1:0] st_data,
    input  logic [SB_OP_W-1:0]   st_op,
    input  logic [SB_PC_W-1:0]   st_pc,
    output logic                 dm_we,
    input  logic                 dm_ready,
    output logic [SB_ADDR_W-1:0] dm_addr,
    output logic [SB_DATA_W-1:0] dm_wd,
    output logic [SB_PC_W-1:0]   dm_pc,
    output logic [SB_OP_W-1:0]   dm_op,
    input  logic                 ld_valid,
    input  logic [SB_ADDR_W-1:0] ld_addr,
    input  logic [SB_OP_W-1:0]   ld_op,
    output logic                 ld_hit,
    output logic [SB_DATA_W-1:0] ld_data,
    output logic                 ld_stall,
    output logic                 empty
);

    logic [SB_ADDR_W-1:0] addr_q [DEPTH];
    logic [SB_DATA_W-1:0] data_q [DEPTH];
    logic [SB_OP_W-1:0]   op_q   [DEPTH];
    logic [SB_PC_W-1:0]   pc_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // A same-cycle pop never frees room for a push into a full queue
    assign st_ready = (count != (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign dm_we    = !empty && reset;
    assign push     = st_valid && st_ready;
    assign pop      = dm_we && dm_ready;

    assign dm_addr = addr_q[head];
    assign dm_wd   = data_q[head];
    assign dm_op   = op_q[head];
    assign dm_pc   = pc_q[head];

    // Entry payload is written at the tail; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            op_q[tail]   <= st_op;
            pc_q[tail]   <= st_pc;
        end
    end

    // Pointers wrap naturally at DEPTH; reset drops all pending stores
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .addr_q   (addr_q),
        .data_q   (data_q),
        .op_q     (op_q),
        .head     (head),
        .count    (count),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_op    (ld_op),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall)
    );

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - scoreboard bench for dm_store_buffer in both SB_FWD_EN builds
module tb_dm_store_buffer;

    localparam logic [1:0] OP_W = 2'b00;
    localparam logic [1:0] OP_H = 2'b01;
    localparam logic [1:0] OP_B = 2'b10;

`ifdef SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_op = '0;
    logic [31:0] st_pc = '0;
    logic        dm_we;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [1:0]  dm_op;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_op = '0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        empty;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dm_store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_op    (st_op),
        .st_pc    (st_pc),
        .dm_we    (dm_we),
        .dm_ready (dm_ready),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_pc    (dm_pc),
        .dm_op    (dm_op),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_op    (ld_op),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .empty    (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every accepted DM write must be the oldest outstanding expected store
    always @(negedge clk) begin
        if (dm_we === 1'b1 && dm_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("dm_unexpected_write", dm_addr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dm_addr", dm_addr, e.addr);
                check("dm_wd", dm_wd, e.data);
                check("dm_op", {30'd0, dm_op}, {30'd0, e.op});
                check("dm_pc", dm_pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op, input logic exp_ready);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_op    = op;
        st_pc    = 32'h1000 + a;
        @(negedge clk);
        check("st_ready", {31'd0, st_ready}, {31'd0, exp_ready});
        if (exp_ready) sb.push_back('{addr: a, data: d, op: op, pc: 32'h1000 + a});
        tick();
        st_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic v, input logic [31:0] a, input logic [1:0] op,
                            input logic eh, input logic [31:0] ed, input logic es);
        ld_valid = v;
        ld_addr  = a;
        ld_op    = op;
        @(negedge clk);
        check({tag, "_hit"}, {31'd0, ld_hit}, {31'd0, eh});
        if (eh) check({tag, "_data"}, ld_data, ed);
        check({tag, "_stall"}, {31'd0, ld_stall}, {31'd0, es});
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        dm_ready = 1'b1;
        while (empty !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_sb", sb.size(), 32'd0);
        dm_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ld_hit", {31'd0, ld_hit}, 32'd0);
        check("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        tick();

        // Basic drain with one cycle of latency
        dm_ready = 1'b1;
        do_push(32'h10, 32'hDEADBEEF, OP_W, 1'b1);
        @(negedge clk);
        check("t1_dm_we", {31'd0, dm_we}, 32'd1);
        check("t1_dm_addr", dm_addr, 32'h10);
        check("t1_dm_wd", dm_wd, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("t1_empty", {31'd0, empty}, 32'd1);
        tick();

        // Fill, refuse fifth push, drain in order, wrap
        dm_ready = 1'b0;
        do_push(32'h0, 32'hA0A0_0000, OP_W, 1'b1);
        do_push(32'h4, 32'hA0A0_0004, OP_W, 1'b1);
        do_push(32'h8, 32'h0000_0088, OP_B, 1'b1);
        do_push(32'hC, 32'h0000_CCCC, OP_H, 1'b1);
        do_push(32'h40, 32'hBAD0_BAD0, OP_W, 1'b0);
        @(negedge clk);
        check("t2_full_ready", {31'd0, st_ready}, 32'd0);
        check("t2_hold_addr", dm_addr, 32'h0);
        check("t2_hold_we", {31'd0, dm_we}, 32'd1);
        tick();
        drain();
        do_push(32'h50, 32'h5555_0050, OP_W, 1'b1);
        do_push(32'h54, 32'h5555_0054, OP_W, 1'b1);
        @(negedge clk);
        check("t2_wrap_head", dm_addr, 32'h50);
        tick();
        drain();

        // Simultaneous push and pop at count 2, then refused push at full with pop
        do_push(32'h60, 32'h6060_6060, OP_W, 1'b1);
        do_push(32'h64, 32'h6464_6464, OP_W, 1'b1);
        dm_ready = 1'b1;
        do_push(32'h68, 32'h6868_6868, OP_W, 1'b1);
        dm_ready = 1'b0;
        @(negedge clk);
        check("t3_head_after_pp", dm_addr, 32'h64);
        tick();
        do_push(32'h6C, 32'h6C6C_6C6C, OP_W, 1'b1);
        do_push(32'h70, 32'h7070_7070, OP_W, 1'b1);
        @(negedge clk);
        check("t3_count_full", {31'd0, st_ready}, 32'd0);
        tick();
        dm_ready = 1'b1;
        do_push(32'h74, 32'hBAD0_0074, OP_W, 1'b0);
        dm_ready = 1'b0;
        @(negedge clk);
        check("t3_after_pop_ready", {31'd0, st_ready}, 32'd1);
        check("t3_after_pop_head", dm_addr, 32'h68);
        tick();
        drain();

        // Load checks against pending stores
        do_push(32'h20, 32'h11223344, OP_W, 1'b1);
        load_chk("w_b22", 1'b1, 32'h22, OP_B, FWD, 32'h22, !FWD);
        load_chk("w_h20", 1'b1, 32'h20, OP_H, FWD, 32'h3344, !FWD);
        load_chk("w_h22", 1'b1, 32'h22, OP_H, FWD, 32'h1122, !FWD);
        load_chk("nomatch", 1'b1, 32'h24, OP_W, 1'b0, 32'h0, 1'b0);
        load_chk("novalid", 1'b0, 32'h20, OP_W, 1'b0, 32'h0, 1'b0);
        do_push(32'h20, 32'h55667788, OP_W, 1'b1);
        load_chk("youngest", 1'b1, 32'h20, OP_W, FWD, 32'h55667788, !FWD);
        do_push(32'h31, 32'h000000AB, OP_B, 1'b1);
        load_chk("b_exact", 1'b1, 32'h31, OP_B, FWD, 32'hAB, !FWD);
        load_chk("b_offset", 1'b1, 32'h30, OP_B, 1'b0, 32'h0, 1'b1);
        load_chk("b_half", 1'b1, 32'h30, OP_H, 1'b0, 32'h0, 1'b1);

        // Partial overlap stalls until the byte store leaves the queue
        ld_valid = 1'b1;
        ld_addr  = 32'h30;
        ld_op    = OP_W;
        dm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("partial_stall_%0d", i), {31'd0, ld_stall}, {31'd0, (i < 3)});
            check($sformatf("partial_hit_%0d", i), {31'd0, ld_hit}, 32'd0);
            tick();
        end
        ld_valid = 1'b0;
        dm_ready = 1'b0;
        check("partial_sb", sb.size(), 32'd0);

        // Reset mid-drain discards pending stores
        do_push(32'h80, 32'h8080_8080, OP_W, 1'b1);
        do_push(32'h84, 32'h8484_8484, OP_W, 1'b1);
        do_push(32'h88, 32'h8888_8888, OP_W, 1'b1);
        reset    = 1'b0;
        dm_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_we_gated", {31'd0, dm_we}, 32'd0);
        sb.delete();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_ready", {31'd0, st_ready}, 32'd1);
        check("rst_mid_we", {31'd0, dm_we}, 32'd0);
        repeat (5) tick();
        dm_ready = 1'b0;
        check("rst_mid_sb", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
